sqrt_arbiter: RTL and testbench

Shares one iterative square-root core among `NREQ` requesters, for example per-axis magnitude consumers. The block selects one requester by round-robin and latches its 16-bit magnitude. It then launches the core with a one-cycle `go`, waits for the core's `done`, and returns the 8-bit root to the winner as a one-cycle valid pulse. A watchdog converts a missing `done` into an error response, so a hung core cannot stall the requesters.

---
 rtl/sqrt_pkg.sv | 16 +
 rtl/rr_pick.sv | 33 +++
 rtl/sqrt_arbiter.sv | 127 ++++++++++++
 tb/tb_sqrt_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared types and constants for the square-root arbiter and its picker.
package sqrt_pkg;

    localparam int MAG_W  = 16;
    localparam int ROOT_W = 8;

    localparam logic [ROOT_W-1:0] ROOT_ERR = 8'h00;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  win,
    output logic [IW-1:0] idx
);

    logic          w_found;
    logic [IW-1:0] w_j;

    // Scan N positions starting one past the previous winner; first hit wins.
    always_comb begin
        win     = '0;
        idx     = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int i = 1; i <= N; i++) begin
            w_j = IW'((int'(last) + i) % N);
            if (!w_found && req[w_j]) begin
                w_found  = 1'b1;
                win[w_j] = 1'b1;
                idx      = w_j;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin sharing of one external iterative square-root core, with a
// watchdog that turns a missing core_done into an error response.
module sqrt_arbiter
    import sqrt_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [MAG_W*NREQ-1:0] mag_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rslt_vld,
    output logic [ROOT_W-1:0]     rslt,
    output logic                  err,
    output logic                  busy,
    output logic                  core_go,
    output logic [MAG_W-1:0]      core_mag,
    input  logic                  core_done,
    input  logic [ROOT_W-1:0]     core_sqrt
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            r_state;
    state_t            w_next;
    logic [IW-1:0]     r_idx;
    logic [IW-1:0]     r_last;
    logic [NREQ-1:0]   r_win;
    logic [TW-1:0]     r_timer;
    logic              r_err_flag;
    logic [ROOT_W-1:0] r_rslt;
    logic [MAG_W-1:0]  r_core_mag;
    logic [NREQ-1:0]   w_pick_win;
    logic [IW-1:0]     w_pick_idx;
    logic              w_timeout;
    logic [MAG_W-1:0]  w_mag [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_mag
        assign w_mag[g] = mag_in[MAG_W*g +: MAG_W];
    end

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req  (req),
        .last (r_last),
        .win  (w_pick_win),
        .idx  (w_pick_idx)
    );

    assign w_timeout = (r_timer == TW'(TIMEOUT));

    // Next-state logic; core_done only matters in WAIT and beats the timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = (|req) ? S_ISSUE : S_IDLE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  w_next = (core_done || w_timeout) ? S_RESP : S_WAIT;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Job datapath: winner capture, watchdog timer, result and pointer update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_last     <= IW'(NREQ - 1);
            r_win      <= '0;
            r_timer    <= '0;
            r_err_flag <= 1'b0;
            r_rslt     <= ROOT_ERR;
            r_core_mag <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_idx      <= w_pick_idx;
                        r_win      <= w_pick_win;
                        r_core_mag <= w_mag[w_pick_idx];
                        r_timer    <= '0;
                    end else begin
                        r_timer    <= r_timer;
                    end
                end
                S_WAIT: begin
                    if (!w_timeout) begin
                        r_timer <= r_timer + TW'(1);
                    end else begin
                        r_timer <= r_timer;
                    end
                    if (core_done) begin
                        r_rslt     <= core_sqrt;
                        r_err_flag <= 1'b0;
                    end else if (w_timeout) begin
                        r_rslt     <= ROOT_ERR;
                        r_err_flag <= 1'b1;
                    end else begin
                        r_rslt     <= r_rslt;
                    end
                end
                S_RESP:  r_last  <= r_idx;
                default: r_timer <= r_timer;
            endcase
        end
    end

    assign gnt      = (r_state == S_ISSUE) ? r_win : '0;
    assign rslt_vld = (r_state == S_RESP)  ? r_win : '0;
    assign err      = (r_state == S_RESP) & r_err_flag;
    assign busy     = (r_state != S_IDLE);
    assign core_go  = (r_state == S_ISSUE);
    assign rslt     = r_rslt;
    assign core_mag = r_core_mag;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter; the bench itself plays the root core.
module tb_sqrt_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] mag_in;
    logic [3:0]  gnt;
    logic [3:0]  rslt_vld;
    logic [7:0]  rslt;
    logic        err;
    logic        busy;
    logic        core_go;
    logic [15:0] core_mag;
    logic        core_done;
    logic [7:0]  core_sqrt;

    int checks = 0;
    int errors = 0;

    sqrt_arbiter #(.NREQ(4), .TIMEOUT(31)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mag_in    (mag_in),
        .gnt       (gnt),
        .rslt_vld  (rslt_vld),
        .rslt      (rslt),
        .err       (err),
        .busy      (busy),
        .core_go   (core_go),
        .core_mag  (core_mag),
        .core_done (core_done),
        .core_sqrt (core_sqrt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'h0);
        chk({tag, "_vld"}, 32'(rslt_vld), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_go"}, 32'(core_go), 32'h0);
        chk({tag, "_rslt"}, 32'(rslt), 32'h0);
        chk({tag, "_mag"}, 32'(core_mag), 32'h0);
    endtask

    // Wait (bounded) for a grant, expecting it exactly exp_wait cycles away,
    // then act as a core with done 'lat' cycles after the grant cycle.
    task automatic run_job(input int exp_idx, input int exp_wait, input logic [15:0] exp_mag,
                           input logic [7:0] root, input int lat, input logic [3:0] drop);
        int n;
        n = 0;
        while (gnt == 4'b0 && n < 10) begin
            tick(1);
            n++;
        end
        chk("gnt_latency", 32'(n), 32'(exp_wait));
        chk("gnt", 32'(gnt), 32'(1) << exp_idx);
        chk("core_go", 32'(core_go), 32'h1);
        chk("core_mag", 32'(core_mag), 32'(exp_mag));
        req = req & ~drop;
        tick(lat);
        chk("vld_before_done", 32'(rslt_vld), 32'h0);
        core_done = 1'b1;
        core_sqrt = root;
        tick(1);
        core_done = 1'b0;
        core_sqrt = 8'hFF;
        chk("rslt_vld", 32'(rslt_vld), 32'(1) << exp_idx);
        chk("rslt", 32'(rslt), 32'(root));
        chk("err", 32'(err), 32'h0);
    endtask

    initial begin
        int n;
        logic [3:0] seen;
        rst_n     = 1'b0;
        req       = 4'b0000;
        mag_in    = {16'h0040, 16'h0019, 16'h0010, 16'h0009};
        core_done = 1'b0;
        core_sqrt = 8'h00;

        // Reset state.
        tick(2);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(1);
        check_reset_outputs("post_reset");

        // All four requesting: grant order 0,1,2,3,0 with back-to-back gap of 2.
        req = 4'b1111;
        run_job(0, 1, 16'h0009, 8'h03, 3, 4'b0000);
        run_job(1, 2, 16'h0010, 8'h04, 4, 4'b0000);
        run_job(2, 2, 16'h0019, 8'h05, 2, 4'b0000);
        run_job(3, 2, 16'h0040, 8'h08, 1, 4'b0000);
        run_job(0, 2, 16'h0009, 8'h03, 5, 4'b1111);

        // Pointer wrap: grant 3 alone, then 0 must beat 2.
        req = 4'b1000;
        run_job(3, 2, 16'h0040, 8'h08, 2, 4'b1000);
        req = 4'b0101;
        run_job(0, 2, 16'h0009, 8'h03, 2, 4'b0001);
        run_job(2, 2, 16'h0019, 8'h05, 2, 4'b0100);
        tick(1);
        chk("idle_after_wrap", 32'(busy), 32'h0);

        // Single request with exact latency after a fresh reset.
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        mag_in[15:0] = 16'h0900;
        req = 4'b0001;
        run_job(0, 1, 16'h0900, 8'h30, 9, 4'b0001);
        tick(1);
        chk("single_idle", 32'(busy), 32'h0);

        // Timeout: core never answers; error response at cycle TIMEOUT+3.
        req = 4'b0010;
        tick(1);
        chk("to_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        tick(32);
        chk("to_not_yet", 32'(rslt_vld), 32'h0);
        chk("to_busy", 32'(busy), 32'h1);
        tick(1);
        chk("to_vld", 32'(rslt_vld), 32'h2);
        chk("to_err", 32'(err), 32'h1);
        chk("to_rslt", 32'(rslt), 32'h00);
        tick(1);
        chk("to_idle", 32'(busy), 32'h0);
        chk("to_err_clear", 32'(err), 32'h0);

        // Reset mid-WAIT: everything back to reset values, no response leaks.
        req = 4'b0100;
        tick(1);
        chk("rst_gnt", 32'(gnt), 32'h4);
        req = 4'b0000;
        tick(5);
        chk("rst_in_wait", 32'(busy), 32'h1);
        rst_n = 1'b0;
        tick(1);
        check_reset_outputs("midwait");
        rst_n = 1'b1;
        seen = 4'b0000;
        n = 0;
        while (n < 8) begin
            tick(1);
            seen = seen | rslt_vld;
            n++;
        end
        chk("no_vld_after_abort", 32'(seen), 32'h0);

        // Stray core_done in IDLE changes nothing.
        core_done = 1'b1;
        core_sqrt = 8'h77;
        tick(1);
        core_done = 1'b0;
        tick(1);
        check_reset_outputs("stray_done");

        // Pointer was reset: requester 0 wins over 1 first.
        req = 4'b0011;
        run_job(0, 1, 16'h0900, 8'h30, 2, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
